// File: rtl/mont_exp_ctrl.sv
// Square-and-multiply sequencer for a shared Montgomery multiplier core.
// Computes x^e mod M from Montgomery-domain operands, then converts the result out of the domain.
module mont_exp_ctrl #(
  parameter int WIDTH  = 512,
  parameter int ELEN_W = 10
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic [WIDTH-1:0]  in_xm,
  input  logic [WIDTH-1:0]  in_rm,
  input  logic [WIDTH-1:0]  in_e,
  input  logic [ELEN_W-1:0] in_elen,
  input  logic [WIDTH-1:0]  in_m,
  output logic              busy,
  output logic              done,
  output logic [WIDTH-1:0]  result,
  output logic              mont_start,
  output logic [WIDTH-1:0]  mont_a,
  output logic [WIDTH-1:0]  mont_b,
  output logic [WIDTH-1:0]  mont_m,
  input  logic [WIDTH-1:0]  mont_result,
  input  logic              mont_done
);

  localparam int IDX_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [ELEN_W-1:0] ELEN_MAX = ELEN_W'(WIDTH);
  localparam logic [ELEN_W-1:0] IDX_ONE  = {{(ELEN_W-1){1'b0}}, 1'b1};
  localparam logic [WIDTH-1:0]  ONE      = {{(WIDTH-1){1'b0}}, 1'b1};

  typedef enum logic [3:0] {
    S_IDLE       = 4'd0,
    S_CHECK      = 4'd1,
    S_SQ_ISSUE   = 4'd2,
    S_SQ_WAIT    = 4'd3,
    S_MUL_ISSUE  = 4'd4,
    S_MUL_WAIT   = 4'd5,
    S_POST_ISSUE = 4'd6,
    S_POST_WAIT  = 4'd7,
    S_DONE       = 4'd8
  } state_t;

  state_t            state_q, state_d;
  logic [WIDTH-1:0]  acc_q, acc_d;
  logic [WIDTH-1:0]  x_q, x_d;
  logic [WIDTH-1:0]  e_q, e_d;
  logic [ELEN_W-1:0] idx_q, idx_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;
  logic [WIDTH-1:0]  result_q, result_d;
  logic              mont_start_q, mont_start_d;
  logic [WIDTH-1:0]  mont_a_q, mont_a_d;
  logic [WIDTH-1:0]  mont_b_q, mont_b_d;
  logic [WIDTH-1:0]  mont_m_q, mont_m_d;
  logic              e_bit;

  // idx has already been decremented in CHECK, so it addresses the bit just squared for
  assign e_bit = e_q[idx_q[IDX_W-1:0]];

  // Next-state and operand-register logic; core operands are loaded one cycle ahead so they are registered
  always_comb begin
    state_d      = state_q;
    acc_d        = acc_q;
    x_d          = x_q;
    e_d          = e_q;
    idx_d        = idx_q;
    busy_d       = busy_q;
    done_d       = 1'b0;
    result_d     = result_q;
    mont_start_d = 1'b0;
    mont_a_d     = mont_a_q;
    mont_b_d     = mont_b_q;
    mont_m_d     = mont_m_q;

    case (state_q)
      S_IDLE: begin
        if (start) begin
          x_d      = in_xm;
          acc_d    = in_rm;
          e_d      = in_e;
          mont_m_d = in_m;
          if (in_elen > ELEN_MAX) begin
            idx_d = ELEN_MAX;
          end else begin
            idx_d = in_elen;
          end
          busy_d  = 1'b1;
          state_d = S_CHECK;
        end else begin
          state_d = S_IDLE;
        end
      end

      S_CHECK: begin
        mont_a_d     = acc_q;
        mont_start_d = 1'b1;
        if (idx_q == {ELEN_W{1'b0}}) begin
          mont_b_d = ONE;
          state_d  = S_POST_ISSUE;
        end else begin
          idx_d    = idx_q - IDX_ONE;
          mont_b_d = acc_q;
          state_d  = S_SQ_ISSUE;
        end
      end

      S_SQ_ISSUE: begin
        state_d = S_SQ_WAIT;
      end

      S_SQ_WAIT: begin
        if (mont_done) begin
          acc_d = mont_result;
          if (e_bit) begin
            mont_a_d     = mont_result;
            mont_b_d     = x_q;
            mont_start_d = 1'b1;
            state_d      = S_MUL_ISSUE;
          end else begin
            state_d = S_CHECK;
          end
        end else begin
          state_d = S_SQ_WAIT;
        end
      end

      S_MUL_ISSUE: begin
        state_d = S_MUL_WAIT;
      end

      S_MUL_WAIT: begin
        if (mont_done) begin
          acc_d   = mont_result;
          state_d = S_CHECK;
        end else begin
          state_d = S_MUL_WAIT;
        end
      end

      S_POST_ISSUE: begin
        state_d = S_POST_WAIT;
      end

      S_POST_WAIT: begin
        if (mont_done) begin
          result_d = mont_result;
          busy_d   = 1'b0;
          done_d   = 1'b1;
          state_d  = S_DONE;
        end else begin
          state_d = S_POST_WAIT;
        end
      end

      S_DONE: begin
        state_d = S_IDLE;
      end

      default: begin
        busy_d  = 1'b0;
        state_d = S_IDLE;
      end
    endcase
  end

  // State and output registers; reset aborts any operation in flight
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= S_IDLE;
      acc_q        <= {WIDTH{1'b0}};
      x_q          <= {WIDTH{1'b0}};
      e_q          <= {WIDTH{1'b0}};
      idx_q        <= {ELEN_W{1'b0}};
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
      result_q     <= {WIDTH{1'b0}};
      mont_start_q <= 1'b0;
      mont_a_q     <= {WIDTH{1'b0}};
      mont_b_q     <= {WIDTH{1'b0}};
      mont_m_q     <= {WIDTH{1'b0}};
    end else begin
      state_q      <= state_d;
      acc_q        <= acc_d;
      x_q          <= x_d;
      e_q          <= e_d;
      idx_q        <= idx_d;
      busy_q       <= busy_d;
      done_q       <= done_d;
      result_q     <= result_d;
      mont_start_q <= mont_start_d;
      mont_a_q     <= mont_a_d;
      mont_b_q     <= mont_b_d;
      mont_m_q     <= mont_m_d;
    end
  end

  assign busy       = busy_q;
  assign done       = done_q;
  assign result     = result_q;
  assign mont_start = mont_start_q;
  assign mont_a     = mont_a_q;
  assign mont_b     = mont_b_q;
  assign mont_m     = mont_m_q;

endmodule
